// File: rtl/axis_uncompress_mlane_pkg.sv
// Shared types and helpers for the multi-lane address uncompressor.
package DataInterfacePkg;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } uz_state_t;

  function automatic int unsigned keep_width(input int unsigned asize, input int unsigned lanes);
    return lanes * ((asize + 7) / 8);
  endfunction

endpackage

// File: rtl/axis_uncompress_mlane.sv
// Expands {base_addr, len} commands into beats of LANES consecutive strided addresses.
module axis_uncompress_mlane
  import DataInterfacePkg::*;
#(
  parameter int unsigned ASIZE    = 8,
  parameter int unsigned LSIZE    = 8,
  parameter int unsigned LANES    = 1,
  parameter int unsigned STRIDE   = 1,
  parameter int unsigned LEN_MODE = 0
) (
  input  logic                               axis_zip_aclk,
  input  logic                               axis_zip_aresetn,
  input  logic                               axis_zip_aclken,
  input  logic [ASIZE+LSIZE-1:0]             axis_zip_tdata,
  input  logic                               axis_zip_tvalid,
  output logic                               axis_zip_tready,
  input  logic                               axis_zip_tlast,
  output logic [LANES*ASIZE-1:0]             axis_unzip_tdata,
  output logic                               axis_unzip_tvalid,
  input  logic                               axis_unzip_tready,
  output logic                               axis_unzip_tlast,
  output logic [keep_width(ASIZE,LANES)-1:0] axis_unzip_tkeep,
  output logic                               axis_unzip_tuser,
  output logic                               zero_len_drop
);

  localparam int unsigned KB = (ASIZE + 7) / 8;
  localparam int unsigned KW = keep_width(ASIZE, LANES);
  localparam int unsigned CW = LSIZE + 1;
  localparam logic [ASIZE-1:0] BEAT_STEP = ASIZE'(LANES * STRIDE);

  uz_state_t state, state_nxt;

  logic [ASIZE-1:0]       next_addr;
  logic [CW-1:0]          remaining;
  logic                   cmd_last;
  logic [LANES*ASIZE-1:0] data_q;
  logic [KW-1:0]          keep_q;
  logic                   last_q;

  logic [ASIZE-1:0]       cmd_base;
  logic [LSIZE-1:0]       cmd_len;
  logic [CW-1:0]          cmd_count;
  logic                   last_beat, zip_hs, beat_hs, load_cmd, load_next;
  logic [ASIZE-1:0]       beat_base;
  logic [CW-1:0]          beat_cnt, beat_rem;
  logic                   beat_tlast, beat_last;
  logic [LANES*ASIZE-1:0] beat_data;
  logic [KW-1:0]          beat_keep;

  assign cmd_base  = axis_zip_tdata[ASIZE+LSIZE-1:LSIZE];
  assign cmd_len   = axis_zip_tdata[LSIZE-1:0];
  assign cmd_count = (LEN_MODE == 0) ? CW'(cmd_len) + CW'(1) : CW'(cmd_len);

  assign last_beat = (state == ST_RUN) && (remaining == '0);
  assign zip_hs    = axis_zip_tvalid && axis_zip_tready;
  assign beat_hs   = axis_unzip_tvalid && axis_unzip_tready && axis_zip_aclken;
  assign load_cmd  = zip_hs && (cmd_count != '0);
  assign load_next = beat_hs && !last_beat;

  always_ff @(posedge axis_zip_aclk or negedge axis_zip_aresetn) begin
    if (!axis_zip_aresetn) state <= ST_IDLE;
    else if (axis_zip_aclken) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (load_cmd) state_nxt = ST_RUN;
      ST_RUN:  if (beat_hs && last_beat && !load_cmd) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    axis_unzip_tvalid = (state == ST_RUN);
    axis_unzip_tuser  = 1'b0;
    axis_zip_tready   = axis_zip_aresetn && axis_zip_aclken &&
                        ((state == ST_IDLE) || (last_beat && axis_unzip_tready));
    zero_len_drop     = zip_hs && (cmd_count == '0) && axis_zip_tlast;
  end

  // A freshly accepted command and a continuing command share one beat builder.
  always_comb begin
    if (load_cmd) begin
      beat_base  = cmd_base;
      beat_cnt   = cmd_count;
      beat_tlast = axis_zip_tlast;
    end else begin
      beat_base  = next_addr;
      beat_cnt   = remaining;
      beat_tlast = cmd_last;
    end
    beat_rem  = (32'(beat_cnt) > LANES) ? beat_cnt - CW'(LANES) : '0;
    beat_last = beat_tlast && (32'(beat_cnt) <= LANES);
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic lane_on;
    assign lane_on = 32'(beat_cnt) > 32'(k);
    assign beat_data[k*ASIZE +: ASIZE] = lane_on ? beat_base + ASIZE'(k * STRIDE) : '0;
    assign beat_keep[k*KB +: KB]       = {KB{lane_on}};
  end

  always_ff @(posedge axis_zip_aclk or negedge axis_zip_aresetn) begin
    if (!axis_zip_aresetn) begin
      next_addr <= '0;
      remaining <= '0;
      cmd_last  <= 1'b0;
      data_q    <= '0;
      keep_q    <= '0;
      last_q    <= 1'b0;
    end else if (axis_zip_aclken) begin
      if (load_cmd || load_next) begin
        data_q    <= beat_data;
        keep_q    <= beat_keep;
        last_q    <= beat_last;
        next_addr <= beat_base + BEAT_STEP;
        remaining <= beat_rem;
      end else if (beat_hs) begin
        data_q <= '0;
        keep_q <= '0;
        last_q <= 1'b0;
      end
      if (load_cmd) cmd_last <= axis_zip_tlast;
    end
  end

  assign axis_unzip_tdata = data_q;
  assign axis_unzip_tkeep = keep_q;
  assign axis_unzip_tlast = last_q;

endmodule

// File: tb/tb_axis_uncompress_mlane.sv
// Bench: two configurations checked against a per-beat address model on every accepted beat.
module tb_axis_uncompress_mlane;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic aclken = 1'b1;
  always #5 clk = ~clk;

  // Instance A: LANES=1 STRIDE=1 LEN_MODE=0
  logic [15:0] za_d;
  logic        za_v = 1'b0, za_l = 1'b0, za_r;
  logic [7:0]  a_d;
  logic [0:0]  a_k;
  logic        a_v, a_r = 1'b1, a_l, a_u, zld_a;
  // Instance B: LANES=4 STRIDE=2 LEN_MODE=1
  logic [15:0] zb_d;
  logic        zb_v = 1'b0, zb_l = 1'b0, zb_r;
  logic [31:0] b_d;
  logic [3:0]  b_k;
  logic        b_v, b_r = 1'b1, b_l, b_u, zld_b;

  axis_uncompress_mlane #(.ASIZE(8), .LSIZE(8), .LANES(1), .STRIDE(1), .LEN_MODE(0)) u_a (
    .axis_zip_aclk(clk), .axis_zip_aresetn(rst_n), .axis_zip_aclken(aclken),
    .axis_zip_tdata(za_d), .axis_zip_tvalid(za_v), .axis_zip_tready(za_r), .axis_zip_tlast(za_l),
    .axis_unzip_tdata(a_d), .axis_unzip_tvalid(a_v), .axis_unzip_tready(a_r),
    .axis_unzip_tlast(a_l), .axis_unzip_tkeep(a_k), .axis_unzip_tuser(a_u),
    .zero_len_drop(zld_a));

  axis_uncompress_mlane #(.ASIZE(8), .LSIZE(8), .LANES(4), .STRIDE(2), .LEN_MODE(1)) u_b (
    .axis_zip_aclk(clk), .axis_zip_aresetn(rst_n), .axis_zip_aclken(aclken),
    .axis_zip_tdata(zb_d), .axis_zip_tvalid(zb_v), .axis_zip_tready(zb_r), .axis_zip_tlast(zb_l),
    .axis_unzip_tdata(b_d), .axis_unzip_tvalid(b_v), .axis_unzip_tready(b_r),
    .axis_unzip_tlast(b_l), .axis_unzip_tkeep(b_k), .axis_unzip_tuser(b_u),
    .zero_len_drop(zld_b));

  typedef struct {
    int base;
    int count;
    bit last;
  } cmd_t;

  cmd_t        qa[$], qb[$];
  logic [63:0] la[$], lb[$];
  int          idx[2];
  bit          stall[2];
  logic [31:0] pd[2];
  logic [3:0]  pk[2];
  logic        pl[2];
  bit          prev_rst = 1'b0;
  int          total = 0, bad = 0;
  int          zld_a_n = 0, zld_b_n = 0, zld_b_exp = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Beat j of a command: addresses j*lanes .. j*lanes+lanes-1, each (base + i*stride) mod 256.
  function automatic void model_beat(input int lanes, input int stride, input int base,
                                     input int count, input int j, input bit cl,
                                     output logic [31:0] d, output logic [3:0] k, output logic l);
    d = '0;
    k = '0;
    for (int ln = 0; ln < lanes; ln++) begin
      int i;
      i = j * lanes + ln;
      if (i < count) begin
        d[ln*8 +: 8] = 8'((base + i * stride) % 256);
        k[ln] = 1'b1;
      end
    end
    l = cl && ((j + 1) * lanes >= count);
  endfunction

  task automatic cmp(input int id, input logic v, input logic r, input logic [31:0] d,
                     input logic [3:0] k, input logic l);
    cmd_t c;
    logic [31:0] ed;
    logic [3:0] ek;
    logic el;
    int lanes, stride, qs;
    lanes  = (id == 0) ? 1 : 4;
    stride = (id == 0) ? 1 : 2;
    if (!rst_n) begin
      chk("reset_out", 64'({v, l, k, d}), 64'd0);
      stall[id] = 1'b0;
      return;
    end
    if (stall[id] && prev_rst)
      chk("stall_hold", 64'({v, l, k, d}), 64'({1'b1, pl[id], pk[id], pd[id]}));
    if (v && r && aclken) begin
      qs = (id == 0) ? qa.size() : qb.size();
      chk("beat_pending", 64'(qs > 0), 64'd1);
      if (qs > 0) begin
        c = (id == 0) ? qa[0] : qb[0];
        model_beat(lanes, stride, c.base, c.count, idx[id], c.last, ed, ek, el);
        chk((id == 0) ? "beat_a" : "beat_b", 64'({l, k, d}), 64'({el, ek, ed}));
        if (id == 0) la.push_back(64'({l, k, d}));
        else lb.push_back(64'({l, k, d}));
        idx[id]++;
        if (idx[id] * lanes >= c.count) begin
          idx[id] = 0;
          if (id == 0) qa.delete(0);
          else qb.delete(0);
        end
      end
    end
    stall[id] = v && !(r && aclken);
    pd[id] = d;
    pk[id] = k;
    pl[id] = l;
  endtask

  always @(negedge clk) begin
    cmp(0, a_v, a_r, {24'b0, a_d}, {3'b0, a_k}, a_l);
    cmp(1, b_v, b_r, b_d, b_k, b_l);
    chk("tuser", 64'({a_u, b_u}), 64'd0);
    if (!rst_n) chk("reset_ctrl", 64'({za_r, zb_r, zld_a, zld_b}), 64'd0);
    else begin
      if (zld_a) zld_a_n++;
      if (zld_b) zld_b_n++;
    end
    prev_rst = rst_n;
  end

  task automatic send(input int id, input int base, input int len, input bit last);
    int count, w;
    bit hs;
    count = (id == 0) ? len + 1 : len;
    if (id == 0) begin za_d = {8'(base), 8'(len)}; za_l = last; za_v = 1'b1; end
    else begin zb_d = {8'(base), 8'(len)}; zb_l = last; zb_v = 1'b1; end
    hs = 1'b0;
    w = 0;
    while (!hs && w < 200) begin
      @(negedge clk);
      hs = (id == 0) ? za_r : zb_r;
      @(posedge clk);
      #1;
      w++;
    end
    if (id == 0) za_v = 1'b0;
    else zb_v = 1'b0;
    if (!hs) chk("zip_accept", 64'(hs), 64'd1);
    else if (count > 0) begin
      if (id == 0) qa.push_back('{base, count, last});
      else qb.push_back('{base, count, last});
    end
  endtask

  task automatic wait_log(input int id, input int n);
    int w = 0;
    while (((id == 0) ? la.size() : lb.size()) < n && w < 500) begin
      @(posedge clk);
      w++;
    end
    #1;
    chk("beats_seen", 64'((id == 0) ? la.size() : lb.size()), 64'(n));
  endtask

  task automatic wait_drain();
    int w = 0;
    while ((qa.size() != 0 || qb.size() != 0) && w < 2000) begin
      @(posedge clk);
      w++;
    end
    #1;
    chk("drain", 64'(qa.size() + qb.size()), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] ed;
    logic [3:0] ek;
    logic el;
    logic [9:0] snap;
    int lb0, z0, w;
    bit rnd_on;

    // Pin the model to hand-computed beats.
    model_beat(4, 2, 'hF8, 6, 0, 1'b1, ed, ek, el);
    chk("model_pin0", 64'({el, ek, ed}), 64'({1'b0, 4'hF, 32'hFEFCFAF8}));
    model_beat(4, 2, 'hF8, 6, 1, 1'b1, ed, ek, el);
    chk("model_pin1", 64'({el, ek, ed}), 64'({1'b1, 4'h3, 32'h00000200}));
    model_beat(1, 1, 'h10, 4, 3, 1'b1, ed, ek, el);
    chk("model_pin2", 64'({el, ek, ed}), 64'({1'b1, 4'h1, 32'h00000013}));

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 64'({a_v, b_v, za_r, zb_r}), 64'b0011);
    @(posedge clk);
    #1;

    // Legacy single-lane sequence.
    la.delete();
    send(0, 'h10, 3, 1'b1);
    wait_log(0, 4);
    if (la.size() >= 4) begin
      chk("s1_beat0", la[0], 64'({1'b0, 4'h1, 32'h10}));
      chk("s1_beat1", la[1], 64'({1'b0, 4'h1, 32'h11}));
      chk("s1_beat2", la[2], 64'({1'b0, 4'h1, 32'h12}));
      chk("s1_beat3", la[3], 64'({1'b1, 4'h1, 32'h13}));
    end

    // Partial final beat with wrap.
    lb.delete();
    send(1, 'hF8, 6, 1'b1);
    wait_log(1, 2);
    if (lb.size() >= 2) begin
      chk("s2_beat0", lb[0], 64'({1'b0, 4'hF, 32'hFEFCFAF8}));
      chk("s2_beat1", lb[1], 64'({1'b1, 4'h3, 32'h00000200}));
    end

    // Back-to-back single-address commands.
    fork
      begin
        send(0, 'h20, 0, 1'b1);
        send(0, 'h30, 0, 1'b1);
        send(0, 'h40, 0, 1'b1);
      end
      begin
        int ww = 0;
        do begin @(negedge clk); ww++; end while (!a_v && ww < 50);
        chk("bubble_1", 64'(a_v), 64'd1);
        @(negedge clk) chk("bubble_2", 64'(a_v), 64'd1);
        @(negedge clk) chk("bubble_3", 64'(a_v), 64'd1);
        @(negedge clk) chk("bubble_end", 64'(a_v), 64'd0);
      end
    join
    @(posedge clk);
    #1;

    // Empty commands.
    lb0 = lb.size();
    z0 = zld_b_n;
    send(1, 'h55, 0, 1'b1);
    zld_b_exp++;
    send(1, 'h56, 0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("empty_zld", 64'(zld_b_n - z0), 64'd1);
    chk("empty_no_beats", 64'(lb.size()), 64'(lb0));
    chk("empty_idle", 64'(b_v), 64'd0);

    // Random backpressure over 200 commands.
    rnd_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          int rb, rl;
          bit rt;
          rb = int'($urandom_range(0, 255));
          rl = int'($urandom_range(0, 9));
          rt = 1'($urandom_range(0, 1));
          if (rl == 0 && rt) zld_b_exp++;
          send(1, rb, rl, rt);
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1 b_r = 1'($urandom_range(0, 1));
        end
      end
    join
    b_r = 1'b1;
    wait_drain();

    // Reset in the middle of an 8-address command.
    send(0, 'h80, 7, 1'b1);
    w = 0;
    while (!(a_v && a_d == 8'h81) && w < 50) begin @(negedge clk); w++; end
    chk("reach_beat2", 64'(a_d), 64'h81);
    @(posedge clk);
    #1 rst_n = 1'b0;
    qa.delete();
    idx[0] = 0;
    #1 chk("async_reset", 64'({a_v, a_l, a_d, za_r}), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk) chk("post_reset", 64'({a_v, za_r}), 64'b01);
    repeat (3) @(negedge clk) chk("no_residual", 64'(a_v), 64'd0);
    @(posedge clk);
    #1;

    // Clock enable low in the middle of a command.
    send(0, 'h90, 7, 1'b0);
    w = 0;
    while (!(a_v && a_d == 8'h92) && w < 50) begin @(negedge clk); w++; end
    chk("reach_ce_point", 64'(a_d), 64'h92);
    @(posedge clk);
    #1 aclken = 1'b0;
    snap = {a_v, a_l, a_d};
    zb_d = 16'h3304;
    zb_l = 1'b1;
    zb_v = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("ce_hold", 64'({a_v, a_l, a_d}), 64'(snap));
      chk("ce_no_zip_hs", 64'({za_r, zb_r, b_v}), 64'd0);
    end
    @(posedge clk);
    #1 aclken = 1'b1;
    zb_v = 1'b0;
    wait_drain();

    chk("zld_total_a", 64'(zld_a_n), 64'd0);
    chk("zld_total_b", 64'(zld_b_n), 64'(zld_b_exp));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
